route_lookup_ctrl: RTL and testbench

- Front-end sequencer directly upstream of the route TCAM.
- Accepts destination-address lookup requests from the packet parser and route-table updates from the management port, and serialises both onto the TCAM's single address/write port.
- Waits out the TCAM result latency, then returns a tagged response (hit, if_idx, prefix_size) to the forwarding stage over a valid/ready handshake.

---
 rtl/route_pkg.sv | 30 +++
 rtl/route_lookup_ctrl.sv | 120 ++++++++++++
 tb/tb_route_lookup_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_pkg.sv
// Shared widths, TCAM bus field layout and controller states for the route lookup front-end.
package route_pkg;

    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = 68;
    localparam int IDX_W   = 8;
    localparam int IF_W    = 4;

    localparam int PREFIX_LSB  = 0;
    localparam int NETMASK_LSB = 32;
    localparam int IF_IDX_LSB  = 64;

    localparam logic [IF_W-1:0] DEFAULT_IF = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        LOOKUP = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A search key occupies the prefix field with every other bit of the bus zeroed.
    function automatic logic [ENTRY_W-1:0] lookup_word(input logic [ADDR_W-1:0] addr);
        logic [ENTRY_W-1:0] word;
        word = '0;
        word[PREFIX_LSB +: ADDR_W] = addr;
        return word;
    endfunction

endpackage

// File: rtl/route_lookup_ctrl.sv
// Serialises route lookups and table updates onto the single TCAM port and returns tagged results.
// Latency: update 1 accept + 1 write cycle; lookup 1 accept + LOOKUP_LAT + 1 response cycle.
// Backpressure: nothing is accepted outside IDLE; RESP holds fields and the TCAM bus until rsp_ready.
module route_lookup_ctrl
    import route_pkg::*;
#(
    parameter int TAG_W         = 8,
    parameter int LOOKUP_LAT    = 2,
    parameter int MAX_UPD_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_index,
    input  logic [ENTRY_W-1:0] upd_data,
    output logic [ENTRY_W-1:0] tcam_addr_in,
    output logic               tcam_wr_en,
    output logic [IDX_W-1:0]   tcam_wr_index,
    input  logic [7:0]         tcam_prefix_size,
    input  logic [IF_W-1:0]    tcam_if_idx,
    input  logic               tcam_valid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_hit,
    output logic [IF_W-1:0]    rsp_if_idx,
    output logic [7:0]         rsp_prefix_size
);

    localparam int                 BURST_W   = $clog2(MAX_UPD_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_UPD_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [3:0]         LAT_LAST  = 4'(LOOKUP_LAT);

    state_t             r_state;
    logic [3:0]         r_lat_cnt;
    logic [BURST_W-1:0] r_upd_burst;
    logic [TAG_W-1:0]   r_req_tag;

    logic w_idle;
    logic w_upd_wins;
    logic w_upd_acc;
    logic w_req_acc;

    // An update only yields to a waiting lookup once it has used up its burst allowance.
    assign w_idle     = (r_state == IDLE);
    assign w_upd_wins = upd_valid && (!req_valid || (r_upd_burst < BURST_MAX));
    assign upd_ready  = w_idle && w_upd_wins;
    assign req_ready  = w_idle && req_valid && !w_upd_wins;
    assign w_upd_acc  = upd_valid && upd_ready;
    assign w_req_acc  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_lat_cnt       <= '0;
            r_upd_burst     <= '0;
            r_req_tag       <= '0;
            tcam_addr_in    <= '0;
            tcam_wr_en      <= 1'b0;
            tcam_wr_index   <= '0;
            rsp_valid       <= 1'b0;
            rsp_tag         <= '0;
            rsp_hit         <= 1'b0;
            rsp_if_idx      <= DEFAULT_IF;
            rsp_prefix_size <= '0;
        end else begin
            tcam_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_upd_acc) begin
                        tcam_wr_en    <= 1'b1;
                        tcam_addr_in  <= upd_data;
                        tcam_wr_index <= upd_index;
                        r_upd_burst   <= req_valid ? (r_upd_burst + BURST_ONE) : '0;
                        r_state       <= WRITE;
                    end else if (w_req_acc) begin
                        tcam_addr_in <= lookup_word(req_addr);
                        r_req_tag    <= req_tag;
                        r_lat_cnt    <= 4'd1;
                        r_upd_burst  <= '0;
                        r_state      <= LOOKUP;
                    end else if (!req_valid) begin
                        r_upd_burst <= '0;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                LOOKUP: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        rsp_valid       <= 1'b1;
                        rsp_tag         <= r_req_tag;
                        rsp_hit         <= tcam_valid;
                        rsp_if_idx      <= tcam_valid ? tcam_if_idx : DEFAULT_IF;
                        rsp_prefix_size <= tcam_valid ? tcam_prefix_size : 8'd0;
                        r_state         <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// Directed bench for route_lookup_ctrl: a LOOKUP_LAT=2 instance plus a LOOKUP_LAT=1 instance.
`timescale 1ns/1ps
module tb_route_lookup_ctrl;
    import route_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    logic        req_valid = 1'b0, req_ready, upd_valid = 1'b0, upd_ready;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_tag = '0, upd_index = '0, tcam_wr_index, tcam_prefix_size, rsp_tag, rsp_prefix_size;
    logic [67:0] upd_data = '0, tcam_addr_in;
    logic        tcam_wr_en, tcam_valid, rsp_valid, rsp_ready = 1'b1, rsp_hit;
    logic [3:0]  tcam_if_idx, rsp_if_idx;
    logic [12:0] r_res_a = '0;

    logic        req_valid_b = 1'b0, req_ready_b, upd_valid_b = 1'b0, upd_ready_b;
    logic [31:0] req_addr_b = '0;
    logic [7:0]  req_tag_b = '0, upd_index_b = '0, tcam_wr_index_b, tcam_prefix_size_b, rsp_tag_b, rsp_prefix_size_b;
    logic [67:0] upd_data_b = '0, tcam_addr_in_b;
    logic        tcam_wr_en_b, tcam_valid_b, rsp_valid_b, rsp_ready_b = 1'b1, rsp_hit_b;
    logic [3:0]  tcam_if_idx_b, rsp_if_idx_b;
    logic [12:0] res_b;

    // TCAM model: {valid, if_idx, len}; misses carry junk fields the controller must replace.
    function automatic logic [12:0] tcam_f(input logic [67:0] bus, input logic we);
        if (!we && bus[67:32] == '0 && bus[31:8] == 24'h0A0001) return {1'b1, 4'h2, 8'd24};
        if (!we && bus[67:32] == '0 && bus[31:16] == 16'hAC10) return {1'b1, 4'h5, 8'd16};
        return {1'b0, 4'h7, 8'd99};
    endfunction

    always @(posedge clk) r_res_a <= tcam_f(tcam_addr_in, tcam_wr_en);
    always @(posedge clk) if (tcam_wr_en) wr_cnt <= wr_cnt + 1;
    assign tcam_valid       = r_res_a[12];
    assign tcam_if_idx      = r_res_a[11:8];
    assign tcam_prefix_size = r_res_a[7:0];

    assign res_b              = tcam_f(tcam_addr_in_b, tcam_wr_en_b);
    assign tcam_valid_b       = res_b[12];
    assign tcam_if_idx_b      = res_b[11:8];
    assign tcam_prefix_size_b = res_b[7:0];

    route_lookup_ctrl #(.TAG_W(8), .LOOKUP_LAT(2), .MAX_UPD_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_data(upd_data),
        .tcam_addr_in(tcam_addr_in), .tcam_wr_en(tcam_wr_en), .tcam_wr_index(tcam_wr_index),
        .tcam_prefix_size(tcam_prefix_size), .tcam_if_idx(tcam_if_idx), .tcam_valid(tcam_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_hit(rsp_hit),
        .rsp_if_idx(rsp_if_idx), .rsp_prefix_size(rsp_prefix_size)
    );

    route_lookup_ctrl #(.TAG_W(8), .LOOKUP_LAT(1), .MAX_UPD_BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b), .req_tag(req_tag_b),
        .upd_valid(upd_valid_b), .upd_ready(upd_ready_b), .upd_index(upd_index_b), .upd_data(upd_data_b),
        .tcam_addr_in(tcam_addr_in_b), .tcam_wr_en(tcam_wr_en_b), .tcam_wr_index(tcam_wr_index_b),
        .tcam_prefix_size(tcam_prefix_size_b), .tcam_if_idx(tcam_if_idx_b), .tcam_valid(tcam_valid_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_tag(rsp_tag_b), .rsp_hit(rsp_hit_b),
        .rsp_if_idx(rsp_if_idx_b), .rsp_prefix_size(rsp_prefix_size_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n = cycle in which rsp_valid first shows, counting the accept cycle as cycle 0.
    task automatic lookup_a(input logic [31:0] addr, input logic [7:0] tag, output int n);
        int guard = 0;
        req_valid = 1'b1; req_addr = addr; req_tag = tag;
        #1;
        while (!req_ready && guard < 30) begin cyc(); guard++; end
        cyc();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 30) begin cyc(); n++; end
    endtask

    task automatic lookup_b(input logic [31:0] addr, input logic [7:0] tag, output int n);
        int guard = 0;
        req_valid_b = 1'b1; req_addr_b = addr; req_tag_b = tag;
        #1;
        while (!req_ready_b && guard < 30) begin cyc(); guard++; end
        cyc();
        req_valid_b = 1'b0;
        n = 1;
        while (!rsp_valid_b && n < 30) begin cyc(); n++; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if (rsp_if_idx !== 4'hF) begin errors++; $display("FAIL reset_rsp_if_idx got=%h exp=f", rsp_if_idx); end
        checks++; if ({rsp_hit, rsp_prefix_size, rsp_tag} !== 17'd0) begin errors++; $display("FAIL reset_rsp_fields got=%h exp=0", {rsp_hit, rsp_prefix_size, rsp_tag}); end
        checks++; if ({tcam_wr_en, tcam_wr_index, tcam_addr_in} !== 77'd0) begin errors++; $display("FAIL reset_tcam_bus got=%h exp=0", {tcam_wr_en, tcam_wr_index, tcam_addr_in}); end
        checks++; if ({req_ready, upd_ready} !== 2'b00) begin errors++; $display("FAIL reset_readys got=%b exp=00", {req_ready, upd_ready}); end
        checks++;
        if ({req_ready_b, upd_ready_b, tcam_wr_en_b, tcam_addr_in_b, tcam_wr_index_b, rsp_valid_b, rsp_tag_b, rsp_hit_b, rsp_prefix_size_b, rsp_if_idx_b}
            !== {3'b000, 68'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 4'hF}) begin
            errors++; $display("FAIL reset_dut_b got=%h", {tcam_addr_in_b, rsp_if_idx_b});
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write_hit();
        int n;
        int wr0;
        upd_valid = 1'b1; upd_index = 8'd3; upd_data = {4'h2, 32'hFFFFFF00, 32'h0A000100};
        #1;
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL wr_upd_ready got=%0b exp=1", upd_ready); end
        wr0 = wr_cnt;
        cyc();
        upd_valid = 1'b0;
        checks++;
        if ({tcam_wr_en, tcam_wr_index, tcam_addr_in} !== {1'b1, 8'd3, 68'h2FFFFFF000A000100}) begin
            errors++; $display("FAIL wr_bus got=%h exp=%h", {tcam_wr_en, tcam_wr_index, tcam_addr_in}, {1'b1, 8'd3, 68'h2FFFFFF000A000100});
        end
        cyc(); cyc();
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL wr_pulse_len got=%0d exp=1", wr_cnt - wr0); end
        checks++; if (tcam_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_low got=%0b exp=0", tcam_wr_en); end
        lookup_a(32'h0A000105, 8'h11, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL hit_latency got=%0d exp=3", n); end
        checks++; if (rsp_tag !== 8'h11) begin errors++; $display("FAIL hit_tag got=%h exp=11", rsp_tag); end
        checks++; if ({rsp_hit, rsp_if_idx, rsp_prefix_size} !== {1'b1, 4'h2, 8'd24}) begin errors++; $display("FAIL hit_fields got=%h exp=%h", {rsp_hit, rsp_if_idx, rsp_prefix_size}, {1'b1, 4'h2, 8'd24}); end
        checks++; if (tcam_addr_in !== {36'd0, 32'h0A000105}) begin errors++; $display("FAIL hit_bus got=%h exp=%h", tcam_addr_in, {36'd0, 32'h0A000105}); end
        cyc();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_rsp_drop got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_miss();
        int n;
        lookup_a(32'hC0A80001, 8'h22, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL miss_latency got=%0d exp=3", n); end
        checks++; if ({rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size} !== {8'h22, 1'b0, 4'hF, 8'd0}) begin
            errors++; $display("FAIL miss_fields got=%h exp=%h", {rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size}, {8'h22, 1'b0, 4'hF, 8'd0});
        end
        cyc();
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        lookup_a(32'hAC100203, 8'h33, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL bp_latency got=%0d exp=3", n); end
        req_valid = 1'b1; req_addr = 32'h01010101; upd_valid = 1'b1; upd_data = 68'hF_12345678_9ABCDEF0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size, req_ready, upd_ready, tcam_wr_en, tcam_addr_in}
                !== {1'b1, 8'h33, 1'b1, 4'h5, 8'd16, 3'b000, 36'd0, 32'hAC100203}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%h", i, {rsp_valid, rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size, req_ready, upd_ready, tcam_wr_en, tcam_addr_in});
            end
            cyc();
        end
        rsp_ready = 1'b1; req_valid = 1'b0; upd_valid = 1'b0;
        cyc();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%0b exp=0", rsp_valid); end
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_after got=%0b exp=1", req_ready); end
        req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_arbitration();
        int seq[$];
        int rsp_cnt = 0;
        upd_valid = 1'b1; upd_index = 8'd9; upd_data = 68'h1_FFFF0000_C0A80000;
        req_valid = 1'b1; req_addr = 32'h0A000107; req_tag = 8'h44;
        for (int i = 0; i < 26; i++) begin
            #1;
            checks++; if (upd_ready && req_ready) begin errors++; $display("FAIL arb_exclusive cycle=%0d got=11 exp=not both", i); end
            if (upd_ready) seq.push_back(0);
            else if (req_ready) seq.push_back(1);
            if (rsp_valid) begin
                rsp_cnt++;
                checks++;
                if ({rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size} !== {8'h44, 1'b1, 4'h2, 8'd24}) begin
                    errors++; $display("FAIL arb_rsp cycle=%0d got=%h", i, {rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size});
                end
            end
            cyc();
        end
        upd_valid = 1'b0; req_valid = 1'b0;
        repeat (6) cyc();
        checks++; if (rsp_cnt !== 2) begin errors++; $display("FAIL arb_rsp_count got=%0d exp=2", rsp_cnt); end
        checks++; if (seq.size() < 10) begin errors++; $display("FAIL arb_accepts got=%0d exp>=10", seq.size()); end
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] !== ((i % 5 == 4) ? 1 : 0)) begin
                errors++; $display("FAIL arb_order idx=%0d got=%0d exp=%0d (1=lookup)", i, seq[i], (i % 5 == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic seen = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0A000109; req_tag = 8'h55;
        cyc();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tcam_wr_en, tcam_addr_in, rsp_valid, rsp_hit, rsp_prefix_size, rsp_tag, rsp_if_idx} !== {1'b0, 68'd0, 1'b0, 1'b0, 8'd0, 8'd0, 4'hF}) begin
            errors++; $display("FAIL rst_lookup got=%h", {tcam_wr_en, tcam_addr_in, rsp_valid, rsp_hit, rsp_prefix_size, rsp_tag, rsp_if_idx});
        end
        cyc();
        rst_n = 1'b1;
        upd_valid = 1'b1; upd_index = 8'd7; upd_data = 68'h3_FF000000_0B000000;
        cyc();
        upd_valid = 1'b0;
        checks++; if (tcam_wr_en !== 1'b1) begin errors++; $display("FAIL rst_write_pre got=%0b exp=1", tcam_wr_en); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({tcam_wr_en, tcam_wr_index} !== 9'd0) begin errors++; $display("FAIL rst_write got=%h exp=0", {tcam_wr_en, tcam_wr_index}); end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen = 1'b1;
            cyc();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rsp got=%0b exp=0", seen); end
        lookup_a(32'hAC10FFFF, 8'h66, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rst_next_latency got=%0d exp=3", n); end
        checks++; if ({rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size} !== {8'h66, 1'b1, 4'h5, 8'd16}) begin
            errors++; $display("FAIL rst_next_fields got=%h", {rsp_tag, rsp_hit, rsp_if_idx, rsp_prefix_size});
        end
        cyc();
    endtask

    task automatic test_lat1();
        int n;
        lookup_b(32'h0A0001AA, 8'h77, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL lat1_latency got=%0d exp=2", n); end
        checks++; if ({rsp_tag_b, rsp_hit_b, rsp_if_idx_b, rsp_prefix_size_b} !== {8'h77, 1'b1, 4'h2, 8'd24}) begin
            errors++; $display("FAIL lat1_hit got=%h", {rsp_tag_b, rsp_hit_b, rsp_if_idx_b, rsp_prefix_size_b});
        end
        cyc();
        lookup_b(32'h01020304, 8'h78, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL lat1_miss_latency got=%0d exp=2", n); end
        checks++; if ({rsp_tag_b, rsp_hit_b, rsp_if_idx_b, rsp_prefix_size_b} !== {8'h78, 1'b0, 4'hF, 8'd0}) begin
            errors++; $display("FAIL lat1_miss got=%h", {rsp_tag_b, rsp_hit_b, rsp_if_idx_b, rsp_prefix_size_b});
        end
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_write_hit();
        test_miss();
        test_backpressure();
        test_arbitration();
        test_async_reset();
        test_lat1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
